mc_ctrl: RTL and testbench

- Multi-cycle main control FSM for the MIPS core.
- Consumes the instruction register produced by the fetch unit and the ALU zero flag.
- Drives the fetch-unit controls (npc_sel, pc_write, rgs_ins_write) plus the datapath, data-memory and CP0 strobes.
- Sits between the fetch unit and the datapath; one instruction takes 3–5 cycles, and interrupts are taken only at instruction boundaries.

---
 rtl/mc_ctrl_pkg.sv | 81 ++++++++
 rtl/mc_ctrl_decode.sv | 57 +++++
 rtl/mc_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS control FSM.
// Holds next-PC select codes, opcode/funct fields, datapath select codes,
// the FSM state encoding and the instruction-class flag bundle.
package mc_ctrl_pkg;

  // Next-PC select codes understood by the fetch unit
  localparam logic [2:0] NPC_SEL_NORMAL    = 3'd0;
  localparam logic [2:0] NPC_SEL_RELATIVE  = 3'd1;
  localparam logic [2:0] NPC_SEL_NRELATIVE = 3'd2;
  localparam logic [2:0] NPC_SEL_REG       = 3'd3;
  localparam logic [2:0] NPC_SEL_EPC       = 3'd4;
  localparam logic [2:0] NPC_SEL_INTERRUPT = 3'd5;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // Funct / COP0 rs sub-codes
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ERET = 6'h18;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [4:0] RS_MF   = 5'h00;
  localparam logic [4:0] RS_MT   = 5'h04;

  // Datapath select codes
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_OR    = 3'd2;
  localparam logic [2:0] ALU_PASSB = 3'd3;
  localparam logic [1:0] WD_ALU    = 2'd0;
  localparam logic [1:0] WD_MEM    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;
  localparam logic [1:0] WD_CP0    = 2'd3;
  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;
  localparam logic [1:0] EXT_ZERO  = 2'd0;
  localparam logic [1:0] EXT_SIGN  = 2'd1;
  localparam logic [1:0] EXT_LUI   = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXE    = 4'd2,
    S_ALUWB  = 4'd3,
    S_MADDR  = 4'd4,
    S_MRD    = 4'd5,
    S_MWR    = 4'd6,
    S_MWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_CP0    = 4'd10,
    S_INT    = 4'd11
  } state_e;

  // One-hot instruction class; all zero means "unsupported, treat as NOP"
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic eret;
    logic mfc0;
    logic mtc0;
  } ins_class_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_decode: combinational instruction classifier.
// Ports: i_ins  - instruction register contents
//        o_cls  - one-hot class flags (all zero for unsupported encodings)
import mc_ctrl_pkg::*;

module mc_decode (
  input  logic [31:0] i_ins,
  output ins_class_t  o_cls
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rs;
  logic       w_unused_ins;

  assign w_op = i_ins[31:26];
  assign w_fn = i_ins[5:0];
  assign w_rs = i_ins[25:21];
  // rt/rd/shamt/immediate fields do not affect the class
  assign w_unused_ins = ^i_ins[20:6];

  // Map opcode/funct/rs fields onto class flags
  always_comb begin
    o_cls = '0;
    case (w_op)
      OP_SPECIAL: begin
        case (w_fn)
          FN_ADDU: o_cls.addu = 1'b1;
          FN_SUBU: o_cls.subu = 1'b1;
          FN_JR:   o_cls.jr   = 1'b1;
          default: o_cls = '0;
        endcase
      end
      OP_ORI:  o_cls.ori = 1'b1;
      OP_LUI:  o_cls.lui = 1'b1;
      OP_LW:   o_cls.lw  = 1'b1;
      OP_SW:   o_cls.sw  = 1'b1;
      OP_BEQ:  o_cls.beq = 1'b1;
      OP_J:    o_cls.j   = 1'b1;
      OP_JAL:  o_cls.jal = 1'b1;
      OP_COP0: begin
        // eret lives in the CO space (rs[4] set); mfc0/mtc0 use exact rs codes
        if (w_rs[4] && (w_fn == FN_ERET)) begin
          o_cls.eret = 1'b1;
        end else if (w_rs == RS_MF) begin
          o_cls.mfc0 = 1'b1;
        end else if (w_rs == RS_MT) begin
          o_cls.mtc0 = 1'b1;
        end else begin
          o_cls = '0;
        end
      end
      default: o_cls = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main control FSM for the MIPS core.
// Inputs : clk, reset (async active-low), ins (IR), zero (ALU equal flag),
//          int_req (CP0-masked interrupt request)
// Outputs: fetch-unit controls (npc_sel, pc_write, rgs_ins_write),
//          GPR/ALU/extender selects, mem_write, CP0 strobes, instr_done.
// Outputs are Moore-style: decoded from the state register and the IR,
// which is stable for the whole instruction once FETCH has loaded it.
import mc_ctrl_pkg::*;

module mc_ctrl #(
  parameter bit INT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ins,
  input  logic        zero,
  input  logic        int_req,
  output logic [2:0]  npc_sel,
  output logic        pc_write,
  output logic        rgs_ins_write,
  output logic        reg_write,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wd_sel,
  output logic [2:0]  alu_op,
  output logic        alu_src_imm,
  output logic [1:0]  ext_op,
  output logic        mem_write,
  output logic        cp0_write,
  output logic        epc_write,
  output logic        exl_set,
  output logic        exl_clr,
  output logic        instr_done
);

  state_e     r_state;
  ins_class_t w_cls;
  logic       w_rtype;
  logic       w_unknown;
  state_e     w_bnd_next;

  mc_decode u_decode (
    .i_ins (ins),
    .o_cls (w_cls)
  );

  assign w_rtype   = w_cls.addu | w_cls.subu;
  assign w_unknown = ~(|w_cls);
  // eret must reach its target before another interrupt can be taken
  assign w_bnd_next = (INT_EN && int_req && !w_cls.eret) ? S_INT : S_FETCH;

  // State register and transitions
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          if (w_rtype | w_cls.ori | w_cls.lui) begin
            r_state <= S_EXE;
          end else if (w_cls.lw | w_cls.sw) begin
            r_state <= S_MADDR;
          end else if (w_cls.beq) begin
            r_state <= S_BRANCH;
          end else if (w_cls.j | w_cls.jal | w_cls.jr | w_cls.eret) begin
            r_state <= S_JUMP;
          end else if (w_cls.mfc0 | w_cls.mtc0) begin
            r_state <= S_CP0;
          end else begin
            r_state <= w_bnd_next;
          end
        end
        S_EXE:    r_state <= S_ALUWB;
        S_MADDR:  r_state <= w_cls.lw ? S_MRD : S_MWR;
        S_MRD:    r_state <= S_MWB;
        S_ALUWB, S_MWR, S_MWB, S_BRANCH, S_JUMP, S_CP0: r_state <= w_bnd_next;
        S_INT:    r_state <= S_FETCH;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // Output decode from state and instruction class
  always_comb begin
    npc_sel       = NPC_SEL_NORMAL;
    pc_write      = 1'b0;
    rgs_ins_write = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = REG_DST_RT;
    wd_sel        = WD_ALU;
    alu_op        = ALU_ADD;
    alu_src_imm   = 1'b0;
    ext_op        = EXT_ZERO;
    mem_write     = 1'b0;
    cp0_write     = 1'b0;
    epc_write     = 1'b0;
    exl_set       = 1'b0;
    exl_clr       = 1'b0;
    instr_done    = 1'b0;
    case (r_state)
      S_FETCH: begin
        rgs_ins_write = 1'b1;
        pc_write      = 1'b1;
      end
      S_DECODE: instr_done = w_unknown;
      S_EXE: begin
        if (w_cls.subu) begin
          alu_op = ALU_SUB;
        end else if (w_cls.ori) begin
          alu_op = ALU_OR;
        end else if (w_cls.lui) begin
          alu_op = ALU_PASSB;
        end else begin
          alu_op = ALU_ADD;
        end
        alu_src_imm = w_cls.ori | w_cls.lui;
        ext_op      = w_cls.lui ? EXT_LUI : EXT_ZERO;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        wd_sel     = WD_ALU;
        reg_dst    = w_rtype ? REG_DST_RD : REG_DST_RT;
        instr_done = 1'b1;
      end
      S_MADDR: begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b1;
        ext_op      = EXT_SIGN;
      end
      S_MRD: instr_done = 1'b0;
      S_MWR: begin
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MWB: begin
        reg_write  = 1'b1;
        wd_sel     = WD_MEM;
        reg_dst    = REG_DST_RT;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_op     = ALU_SUB;
        instr_done = 1'b1;
        // PC already holds PC+4, so the relative target is formed from it
        if (zero) begin
          pc_write = 1'b1;
          npc_sel  = NPC_SEL_RELATIVE;
        end else begin
          pc_write = 1'b0;
          npc_sel  = NPC_SEL_NORMAL;
        end
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (w_cls.j) begin
          npc_sel = NPC_SEL_NRELATIVE;
        end else if (w_cls.jal) begin
          npc_sel   = NPC_SEL_NRELATIVE;
          reg_write = 1'b1;
          reg_dst   = REG_DST_RA;
          wd_sel    = WD_PC;
        end else if (w_cls.jr) begin
          npc_sel = NPC_SEL_REG;
        end else begin
          npc_sel = NPC_SEL_EPC;
          exl_clr = 1'b1;
        end
      end
      S_CP0: begin
        instr_done = 1'b1;
        if (w_cls.mfc0) begin
          reg_write = 1'b1;
          wd_sel    = WD_CP0;
          reg_dst   = REG_DST_RT;
        end else begin
          cp0_write = 1'b1;
        end
      end
      S_INT: begin
        pc_write  = 1'b1;
        npc_sel   = NPC_SEL_INTERRUPT;
        epc_write = 1'b1;
        exl_set   = 1'b1;
      end
      default: npc_sel = NPC_SEL_NORMAL;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed + randomized bench for mc_ctrl. The reference model
// describes each instruction as its list of per-cycle strobe vectors.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ins;
  logic        zero;
  logic        int_req;
  logic [2:0]  npc_sel;
  logic        pc_write, rgs_ins_write, reg_write;
  logic [1:0]  reg_dst, wd_sel;
  logic [2:0]  alu_op;
  logic        alu_src_imm;
  logic [1:0]  ext_op;
  logic        mem_write, cp0_write, epc_write, exl_set, exl_clr, instr_done;

  mc_ctrl #(.INT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .ins(ins), .zero(zero), .int_req(int_req),
    .npc_sel(npc_sel), .pc_write(pc_write), .rgs_ins_write(rgs_ins_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .ext_op(ext_op), .mem_write(mem_write),
    .cp0_write(cp0_write), .epc_write(epc_write), .exl_set(exl_set),
    .exl_clr(exl_clr), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] npc_sel;
    logic       pc_write;
    logic       rgs_ins_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic [2:0] alu_op;
    logic       alu_src_imm;
    logic [1:0] ext_op;
    logic       mem_write;
    logic       cp0_write;
    logic       epc_write;
    logic       exl_set;
    logic       exl_clr;
    logic       instr_done;
  } ov_t;

  ov_t got;
  assign got = {npc_sel, pc_write, rgs_ins_write, reg_write, reg_dst, wd_sel,
                alu_op, alu_src_imm, ext_op, mem_write, cp0_write, epc_write,
                exl_set, exl_clr, instr_done};

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_J = 7, K_JAL = 8, K_JR = 9,
                 K_ERET = 10, K_MFC0 = 11, K_MTC0 = 12, K_UNK = 13;

  int  checks = 0;
  int  failures = 0;
  ov_t exp_q[$];

  function automatic ov_t v_fetch();
    ov_t v = '0;
    v.rgs_ins_write = 1'b1;
    v.pc_write      = 1'b1;
    return v;
  endfunction

  // Expected per-cycle vectors for one instruction (+ INT if taken).
  // mode: 0 = no request, 1 = request held, 2 = request only in cycle 2.
  task automatic build(input int kind, input logic z, input int mode);
    ov_t v;
    logic irq;
    exp_q.delete();
    exp_q.push_back(v_fetch());
    v = '0;
    if (kind == K_UNK) v.instr_done = 1'b1;
    exp_q.push_back(v);
    case (kind)
      K_ADDU, K_SUBU, K_ORI, K_LUI: begin
        v = '0;
        v.alu_op = (kind == K_SUBU) ? 3'd1 : (kind == K_ORI) ? 3'd2 :
                   (kind == K_LUI) ? 3'd3 : 3'd0;
        v.alu_src_imm = (kind == K_ORI) || (kind == K_LUI);
        v.ext_op = (kind == K_LUI) ? 2'd2 : 2'd0;
        exp_q.push_back(v);
        v = '0; v.reg_write = 1'b1; v.instr_done = 1'b1;
        v.reg_dst = (kind == K_ADDU || kind == K_SUBU) ? 2'd1 : 2'd0;
        exp_q.push_back(v);
      end
      K_LW, K_SW: begin
        v = '0; v.alu_src_imm = 1'b1; v.ext_op = 2'd1;
        exp_q.push_back(v);
        if (kind == K_LW) begin
          v = '0; exp_q.push_back(v);
          v = '0; v.reg_write = 1'b1; v.wd_sel = 2'd1; v.instr_done = 1'b1;
          exp_q.push_back(v);
        end else begin
          v = '0; v.mem_write = 1'b1; v.instr_done = 1'b1;
          exp_q.push_back(v);
        end
      end
      K_BEQ: begin
        v = '0; v.alu_op = 3'd1; v.instr_done = 1'b1;
        v.pc_write = z; v.npc_sel = z ? 3'd1 : 3'd0;
        exp_q.push_back(v);
      end
      K_J, K_JAL, K_JR, K_ERET: begin
        v = '0; v.pc_write = 1'b1; v.instr_done = 1'b1;
        v.npc_sel = (kind == K_JR) ? 3'd3 : (kind == K_ERET) ? 3'd4 : 3'd2;
        if (kind == K_JAL) begin
          v.reg_write = 1'b1; v.reg_dst = 2'd2; v.wd_sel = 2'd2;
        end
        v.exl_clr = (kind == K_ERET);
        exp_q.push_back(v);
      end
      K_MFC0: begin
        v = '0; v.reg_write = 1'b1; v.wd_sel = 2'd3; v.instr_done = 1'b1;
        exp_q.push_back(v);
      end
      K_MTC0: begin
        v = '0; v.cp0_write = 1'b1; v.instr_done = 1'b1;
        exp_q.push_back(v);
      end
      default: ;
    endcase
    // request is looked at only in the final (boundary) cycle
    irq = (mode == 1) || (mode == 2 && exp_q.size() - 1 == 2);
    if (irq && kind != K_ERET) begin
      v = '0; v.pc_write = 1'b1; v.npc_sel = 3'd5; v.epc_write = 1'b1;
      v.exl_set = 1'b1;
      exp_q.push_back(v);
    end
  endtask

  function automatic logic [31:0] enc(input int kind);
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    imm = 16'($urandom); tgt = 26'($urandom);
    case (kind)
      K_ADDU: return {6'h00, rs, rt, rd, 5'h00, 6'h21};
      K_SUBU: return {6'h00, rs, rt, rd, 5'h00, 6'h23};
      K_ORI:  return {6'h0d, rs, rt, imm};
      K_LUI:  return {6'h0f, 5'h00, rt, imm};
      K_LW:   return {6'h23, rs, rt, imm};
      K_SW:   return {6'h2b, rs, rt, imm};
      K_BEQ:  return {6'h04, rs, rt, imm};
      K_J:    return {6'h02, tgt};
      K_JAL:  return {6'h03, tgt};
      K_JR:   return {6'h00, rs, 15'h0000, 6'h08};
      K_ERET: return 32'h42000018;
      K_MFC0: return {6'h10, 5'h00, rt, rd, 11'h000};
      K_MTC0: return {6'h10, 5'h04, rt, rd, 11'h000};
      K_UNK:  return ($urandom_range(0, 1) == 0) ? {6'h08, rs, rt, imm}
                                                 : {6'h00, rs, rt, rd, 5'h00, 6'h20};
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Drive one instruction from FETCH, checking every cycle (up to limit)
  task automatic run(input string tag, input logic [31:0] instr, input int kind,
                     input logic z, input int mode, input int limit);
    int n;
    build(kind, z, mode);
    n = (limit < exp_q.size()) ? limit : exp_q.size();
    for (int k = 0; k < n; k++) begin
      ins = instr;
      zero = z;
      int_req = (mode == 1) || (mode == 2 && k == 2);
      #1;
      checks++;
      assert (got === exp_q[k]) else begin
        failures++;
        $error("FAIL %s cyc=%0d got=%h exp=%h", tag, k, got, exp_q[k]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int kind, mode;
    reset = 1'b0; ins = 32'h0000_0000; zero = 1'b0; int_req = 1'b0;
    #1;
    checks++;
    assert (got === v_fetch()) else begin
      failures++;
      $error("FAIL reset got=%h exp=%h", got, v_fetch());
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Abort lw in MRD with an asynchronous reset
    run("lw_pre", 32'h8C820004, K_LW, 1'b0, 0, 3);
    #2 reset = 1'b0;
    #1;
    checks++;
    assert (got === v_fetch()) else begin
      failures++;
      $error("FAIL rst_async got=%h exp=%h", got, v_fetch());
    end
    @(negedge clk);
    #1;
    checks++;
    assert (got === v_fetch()) else begin
      failures++;
      $error("FAIL rst_hold got=%h exp=%h", got, v_fetch());
    end
    @(negedge clk);
    reset = 1'b1;

    run("addu",      32'h00851021, K_ADDU, 1'b0, 0, 99);
    run("lw",        32'h8C820004, K_LW,   1'b0, 0, 99);
    run("sw",        32'hAC820004, K_SW,   1'b0, 0, 99);
    run("beq_taken", 32'h10850003, K_BEQ,  1'b1, 0, 99);
    run("beq_not",   32'h10850003, K_BEQ,  1'b0, 0, 99);
    run("jal",       32'h0C000C10, K_JAL,  1'b0, 0, 99);
    run("eret",      32'h42000018, K_ERET, 1'b0, 0, 99);
    run("eret_irq",  32'h42000018, K_ERET, 1'b0, 1, 99);
    run("addu_irq",  32'h00851021, K_ADDU, 1'b0, 1, 99);
    run("addu_puls", 32'h00851021, K_ADDU, 1'b0, 2, 99);
    run("unk_irq",   32'h20000000, K_UNK,  1'b0, 1, 99);

    for (int i = 0; i < 80; i++) begin
      kind = int'($urandom_range(0, 13));
      mode = ($urandom_range(0, 3) == 0) ? 1 : (($urandom_range(0, 3) == 0) ? 2 : 0);
      run("rand", enc(kind), kind, 1'($urandom_range(0, 1)), mode, 99);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
